// File: rtl/xnorpop_sequencer_if.sv
// Handshake and operand bus between the neuron sequencer, its operand buffer and the result collector.
// The sequencer uses the slave modport; the buffer/collector side uses master.
interface xnorpop_sequencer_if #(
    parameter int CHUNK      = 576,
    parameter int NUM_CHUNKS = 4
);
    localparam int N     = CHUNK * NUM_CHUNKS;
    localparam int ACC_W = $clog2(N + 1);
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    logic                    start;
    logic [ACC_W-1:0]        thr;
    logic                    busy;
    logic                    chunk_req;
    logic [IDX_W-1:0]        chunk_idx;
    logic                    chunk_valid;
    logic [CHUNK-1:0]        a_chunk;
    logic [CHUNK-1:0]        w_chunk;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        sum;
    logic signed [ACC_W:0]   dot;
    logic                    act;

    modport slave (
        input  start, thr, chunk_valid, a_chunk, w_chunk, out_ready,
        output busy, chunk_req, chunk_idx, out_valid, sum, dot, act
    );

    modport master (
        output start, thr, chunk_valid, a_chunk, w_chunk, out_ready,
        input  busy, chunk_req, chunk_idx, out_valid, sum, dot, act
    );
endinterface

// File: rtl/xnorpop_sequencer.sv
// Binarized neuron: streams NUM_CHUNKS operand chunks through one XNOR-popcount datapath,
// accumulates the matches and reports sum, signed dot product and thresholded activation.
module xnorpop_sequencer #(
    parameter int CHUNK      = 576,
    parameter int NUM_CHUNKS = 4
) (
    input logic                clk,
    input logic                rst_n,
    xnorpop_sequencer_if.slave bus
);
    localparam int N     = CHUNK * NUM_CHUNKS;
    localparam int ACC_W = $clog2(N + 1);
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int POP_W = $clog2(CHUNK);
    localparam logic [IDX_W-1:0]        LAST = IDX_W'(NUM_CHUNKS - 1);
    localparam logic signed [ACC_W:0]   N_S  = (ACC_W + 1)'(N);

    typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

    state_t                state, state_nxt;
    logic [ACC_W-1:0]      acc, thr_q, sum_q, acc_sum;
    logic [IDX_W-1:0]      cnt;
    logic [POP_W-1:0]      pop, pop_q;
    logic signed [ACC_W:0] dot_q;
    logic                  act_q;

    XNORPop #(.pop_size(CHUNK), .Majority_enable(1'b0)) u_pop (
        .a      (bus.a_chunk),
        .w      (bus.w_chunk),
        .result (pop)
    );

    assign acc_sum = acc + ACC_W'(pop_q);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start)       state_nxt = FETCH;
            FETCH:   if (bus.chunk_valid) state_nxt = ACC;
            ACC:     state_nxt = (cnt == LAST) ? DONE : FETCH;
            DONE:    if (bus.out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            thr_q <= '0;
            cnt   <= '0;
            pop_q <= '0;
            sum_q <= '0;
            dot_q <= '0;
            act_q <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (bus.start) begin
                    thr_q <= bus.thr;
                    acc   <= '0;
                    cnt   <= '0;
                end
                FETCH: if (bus.chunk_valid) pop_q <= pop;
                ACC: begin
                    acc <= acc_sum;
                    // Result regs load once, on the final accumulate, so they hold steady through DONE.
                    if (cnt == LAST) begin
                        sum_q <= acc_sum;
                        dot_q <= $signed({acc_sum, 1'b0}) - N_S;
                        act_q <= (acc_sum >= thr_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.chunk_req = (state == FETCH);
    assign bus.chunk_idx = cnt;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.dot       = dot_q;
    assign bus.act       = act_q;
endmodule

// XNOR-popcount datapath; pop_size must not be a power of two so the count fits $clog2(pop_size) bits.
module XNORPop #(
    parameter int  pop_size        = 9,
    parameter bit  Majority_enable = 1'b0,
    localparam int OUT_W           = $clog2(pop_size)
) (
    input  logic [pop_size-1:0] a,
    input  logic [pop_size-1:0] w,
    output logic [OUT_W-1:0]    result
);
    logic [pop_size-1:0] match;
    logic [OUT_W-1:0]    cnt;

    assign match = a ~^ w;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < pop_size; i++) cnt = cnt + OUT_W'(match[i]);
    end

    generate
        if (Majority_enable) begin : g_maj
            assign result = OUT_W'(cnt > OUT_W'(pop_size / 2));
        end else begin : g_pop
            assign result = cnt;
        end
    endgenerate
endmodule
